pc_seq_unit: RTL and testbench
==============================

PC_SEQ_UNIT -- requirements
Module: pc_seq_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, PC value after reset.
REQ-003 SHALL have parameter CPI, default 5, cycles per instruction; legal range 1..8.
REQ-004 SHALL have parameter ILEN_BYTES, default 4, sequential increment; power of two.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port stall_i  input  1  freeze phase counter and PC.
REQ-008 SHALL have port redirect_valid_i  input  1  branch/jump target present this cycle.
REQ-009 SHALL have port redirect_pc_i  input  XLEN  redirect target.
REQ-010 SHALL have port pc_o  output  XLEN  current PC, registered.
REQ-011 SHALL have port pc_valid_o  output  1  high while state RUN and phase 0.
REQ-012 SHALL have port phase_o  output  3  phase within instruction, 0..CPI-1.
REQ-013 SHALL have port misalign_o  output  1  one-cycle pulse on dropped misaligned redirect.

Function
REQ-014 SHALL implement states START and RUN; START lasts exactly one cycle after reset release with pc_o=RESET_VEC, then RUN with phase_o=0.
REQ-015 SHALL, in RUN without stall, increment phase_o each cycle, wrapping CPI-1 -> 0; the cycle at phase CPI-1 is the boundary.
REQ-016 SHALL, at a boundary, load pc_o with the pending/current redirect target if any, else pc_o+ILEN_BYTES modulo 2^XLEN (wrap, no flag).
REQ-017 SHALL latch a redirect arriving off-boundary into a pending register, applied at the next boundary, then cleared.
REQ-018 SHALL, for multiple redirects before one boundary, keep the latest; a redirect at the boundary cycle overrides a pending one and applies at that boundary.
REQ-019 SHALL, while stall_i=1, hold pc_o and phase_o; redirects still latch into pending.
REQ-020 SHALL ignore stall_i and redirect_valid_i in START; a redirect there is not latched.
REQ-021 SHALL, when CPI=1, keep phase_o=0 and treat every unstalled RUN cycle as a boundary.
REQ-022 SHALL update pc_o no earlier than the clock edge ending the boundary cycle (one-cycle latency).

Reset
REQ-023 SHALL, on rst_n low at any time including mid-instruction, immediately set pc_o=RESET_VEC, phase_o=0, state=START, pending cleared, misalign_o=0, pc_valid_o=0.

Configuration
REQ-024 SHALL, with PC_ALIGN_CHECK_EN defined, drop any redirect whose low log2(ILEN_BYTES) bits are nonzero (pending unchanged) and pulse misalign_o for one cycle the cycle after.
REQ-025 SHALL, without PC_ALIGN_CHECK_EN, accept all redirect targets unchanged and tie misalign_o to 0.

Structure
REQ-026 SHALL place the state enum (START, RUN) and phase width constant in shared package pc_pkg.
REQ-027 SHALL implement the phase counter as sub-module pc_phase_cnt (enable, wrap at CPI-1, boundary flag).

Verification
REQ-028 SHALL cover: reset release, CPI=5, no stall -> pc_o 0 for START plus 5 RUN cycles, then 4, 8, 12 every 5 cycles.
REQ-029 SHALL cover: redirect 0x100 at phase 2 with pc 0x8 -> pc_o=0x100 after boundary, not 0xC.
REQ-030 SHALL cover: redirects 0x40 at phase 1 and 0x80 at phase 3 -> next pc_o=0x80.
REQ-031 SHALL cover: stall_i high 3 cycles at phase 2 -> phase_o and pc_o frozen; boundary delayed exactly 3 cycles.
REQ-032 SHALL cover: PC_ALIGN_CHECK_EN, redirect 0x102 -> misalign_o pulse, pc_o continues sequentially; undefined -> pc_o=0x102.
REQ-033 SHALL cover: XLEN=32, RESET_VEC=32'hFFFF_FFFC, CPI=1 -> pc_o FFFF_FFFC, FFFF_FFFC, 0, 4; rst_n low mid-run -> pc_o=FFFF_FFFC same cycle.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC sequencer.
package pc_pkg;
  typedef enum logic {START, RUN} pc_state_e;
  localparam int PHASE_W = 3;
endpackage

// File: rtl/pc_phase_cnt.sv
// Phase-within-instruction counter; boundary flags the enabled cycle at phase CPI-1.
module pc_phase_cnt
  import pc_pkg::*;
#(
  parameter int CPI = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [PHASE_W-1:0] phase,
  output logic               boundary
);
  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(CPI - 1);

  assign boundary = en && (phase == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      phase <= '0;
    else if (en)
      phase <= (phase == LAST) ? '0 : phase + 1'b1;
  end
endmodule

// File: rtl/pc_seq_unit.sv
// Multi-cycle PC sequencer with deferred redirects and stall.
// Optional PC_ALIGN_CHECK_EN drops misaligned redirect targets and pulses misalign_o.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int              CPI        = 5,
  parameter int              ILEN_BYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_valid_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic [XLEN-1:0]    pc_o,
  output logic               pc_valid_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic               misalign_o
);
  pc_state_e       state;
  logic            boundary;
  logic            pend_v;
  logic [XLEN-1:0] pend_pc;
  logic            aligned;
  logic            redir_ok;

  pc_phase_cnt #(.CPI(CPI)) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       ((state == RUN) && !stall_i),
    .phase    (phase_o),
    .boundary (boundary)
  );

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);
  assign aligned = ((redirect_pc_i & ALIGN_MASK) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misalign_o <= 1'b0;
    else
      misalign_o <= (state == RUN) && redirect_valid_i && !aligned;
  end
`else
  assign aligned    = 1'b1;
  assign misalign_o = 1'b0;
`endif

  // Redirects are only honoured in RUN; stall does not block latching.
  assign redir_ok   = (state == RUN) && redirect_valid_i && aligned;
  assign pc_valid_o = (state == RUN) && (phase_o == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= START;
      pc_o    <= RESET_VEC;
      pend_v  <= 1'b0;
      pend_pc <= '0;
    end else begin
      case (state)
        START: state <= RUN;
        RUN: begin
          if (boundary) begin
            // A redirect landing on the boundary cycle beats an older pending one.
            if (redir_ok)    pc_o <= redirect_pc_i;
            else if (pend_v) pc_o <= pend_pc;
            else             pc_o <= pc_o + XLEN'(ILEN_BYTES);
            pend_v <= 1'b0;
          end else if (redir_ok) begin
            pend_v  <= 1'b1;
            pend_pc <= redirect_pc_i;
          end
        end
        default: state <= START;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_seq_unit.sv
// Randomized + directed bench for pc_seq_unit against a cycle-count reference model.
module tb_pc_seq_unit;
  localparam int CPI  = 5;
  localparam int ILEN = 4;

  logic        clk = 1'b0;
  logic        rst_n, rst1_n;
  logic        stall_i, redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o, b_pc;
  logic        pc_valid_o, misalign_o, b_valid, b_mis;
  logic [2:0]  phase_o, b_phase;
  logic        b_stall = 1'b0, b_rv = 1'b0;
  logic [31:0] b_rpc = '0;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit          m_started;
  int          m_n;      // unstalled RUN cycles since reset
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  bit          m_mis;

  always #5 clk = ~clk;

  pc_seq_unit u_dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .phase_o(phase_o), .misalign_o(misalign_o)
  );

  pc_seq_unit #(.XLEN(32), .RESET_VEC(32'hFFFF_FFFC), .CPI(1), .ILEN_BYTES(4)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .stall_i(b_stall),
    .redirect_valid_i(b_rv), .redirect_pc_i(b_rpc),
    .pc_o(b_pc), .pc_valid_o(b_valid), .phase_o(b_phase), .misalign_o(b_mis)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_phase();
    return m_n % CPI;
  endfunction

  task automatic model_reset();
    m_started = 0; m_n = 0; m_pc = 32'h0; m_pend.delete(); m_mis = 0;
  endtask

  task automatic model_step(input logic s, input logic rv, input logic [31:0] rpc);
    bit ok, good_align;
    if (!m_started) begin
      m_started = 1; m_mis = 0;
      return;
    end
`ifdef PC_ALIGN_CHECK_EN
    good_align = (rpc % ILEN) == 0;
`else
    good_align = 1;
`endif
    m_mis = rv && !good_align;
    ok = rv && good_align;
    if (!s && (m_phase() == CPI - 1)) begin
      if (ok)                     m_pc = rpc;
      else if (m_pend.size() > 0) m_pc = m_pend[0];
      else                        m_pc = m_pc + ILEN;
      m_pend.delete();
    end else if (ok) begin
      m_pend.delete();
      m_pend.push_back(rpc);
    end
    if (!s) m_n++;
  endtask

  task automatic check_all();
    chk("pc", pc_o, m_pc);
    chk("phase", 32'(phase_o), 32'(m_phase()));
    chk("pc_valid", 32'(pc_valid_o), 32'(m_started && m_phase() == 0));
    chk("misalign", 32'(misalign_o), 32'(m_mis));
  endtask

  task automatic cyc(input logic s, input logic rv, input logic [31:0] rpc);
    stall_i = s; redirect_valid_i = rv; redirect_pc_i = rpc;
    @(posedge clk);
    model_step(s, rv, rpc);
    @(negedge clk);
    check_all();
  endtask

  task automatic go_phase(input int p);
    for (int i = 0; i < 2 * CPI; i++) begin
      if (m_phase() == p) break;
      cyc(0, 0, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] saved;
    int          cnt;
    logic        s, rv;
    logic [31:0] rpc;

    rst_n = 0; rst1_n = 0;
    stall_i = 0; redirect_valid_i = 0; redirect_pc_i = '0;
    model_reset();

    // CPI=1, wrap from top of address space
    repeat (2) @(negedge clk);
    rst1_n = 1;
    #1;
    chk("b_start_pc", b_pc, 32'hFFFF_FFFC);
    chk("b_start_valid", 32'(b_valid), 32'h0);
    @(negedge clk); chk("b_pc1", b_pc, 32'hFFFF_FFFC); chk("b_valid1", 32'(b_valid), 32'h1);
    @(negedge clk); chk("b_pc2", b_pc, 32'h0000_0000); chk("b_phase", 32'(b_phase), 32'h0);
    @(negedge clk); chk("b_pc3", b_pc, 32'h0000_0004); chk("b_mis", 32'(b_mis), 32'h0);
    #2 rst1_n = 0;
    #1 chk("b_async_rst", b_pc, 32'hFFFF_FFFC);

    // default instance: release reset, START cycle then RUN
    @(negedge clk);
    rst_n = 1;
    #1 check_all();
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 0, 32'h0);
      chk("seq_pc", pc_o, (k < 6) ? 32'h0 : 32'(4 * ((k - 1) / 5)));
    end

    // redirect mid-instruction wins over sequential increment
    go_phase(2);
    chk("pre_redir_pc", pc_o, 32'h8);
    cyc(0, 1, 32'h100);
    go_phase(0);
    chk("redir_100", pc_o, 32'h100);

    // latest of two pending redirects applies
    go_phase(1);
    cyc(0, 1, 32'h40);
    go_phase(3);
    cyc(0, 1, 32'h80);
    go_phase(0);
    chk("redir_latest", pc_o, 32'h80);

    // 3-cycle stall at phase 2 delays boundary by exactly 3
    go_phase(2);
    saved = m_pc;
    repeat (3) begin
      cyc(1, 0, 32'h0);
      chk("stall_phase", 32'(phase_o), 32'h2);
      chk("stall_pc", pc_o, saved);
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 32'h0);
      cnt++;
      if (pc_o !== saved) break;
    end
    chk("stall_delay", 32'(cnt), 32'h3);

    // misaligned redirect
    go_phase(1);
    saved = m_pc;
    cyc(0, 1, 32'h102);
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_pulse", 32'(misalign_o), 32'h1);
    go_phase(0);
    chk("mis_seq_pc", pc_o, saved + 32'h4);
`else
    chk("mis_pulse", 32'(misalign_o), 32'h0);
    go_phase(0);
    chk("mis_accept_pc", pc_o, 32'h102);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      s   = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 3) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      cyc(s, rv, rpc);
    end

    // async reset mid-run
    go_phase(3);
    #3 rst_n = 0;
    #1;
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_phase", 32'(phase_o), 32'h0);
    chk("rst_valid", 32'(pc_valid_o), 32'h0);
    chk("rst_mis", 32'(misalign_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
